// File: rtl/regfile_responder.sv
// rtl/regfile_responder.sv - 2-read/1-write register file with write bypass, zero register and clear sweep
module regfile_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ReadAddr1,
    input  logic [ADDR_W-1:0] ReadAddr2,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic              ClearReq,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              ClearBusy,
    output logic              ClearDone,
    output logic              WriteDropped
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic              busy_next, done_next, dropped_next;
    logic              host_write, wr_en, clr_en;

    // Register 0 is never stored; it is synthesised as a constant zero on the read path.
    logic [DATA_W-1:0] regs [1:NUM_REGS-1];

    assign host_write = RegWrite && (WriteAddr != '0);

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        done_next    = 1'b0;
        dropped_next = 1'b0;
        wr_en        = 1'b0;
        clr_en       = 1'b0;
        case (state)
            IDLE: begin
                wr_en = host_write;
                if (ClearReq) begin
                    state_next = CLEAR;
                    ptr_next   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                clr_en       = 1'b1;
                dropped_next = host_write;
                if (ptr == LAST_PTR) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    ptr_next = ptr + ADDR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == CLEAR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ptr          <= '0;
            ClearBusy    <= 1'b0;
            ClearDone    <= 1'b0;
            WriteDropped <= 1'b0;
        end else begin
            state        <= state_next;
            ptr          <= ptr_next;
            ClearBusy    <= busy_next;
            ClearDone    <= done_next;
            WriteDropped <= dropped_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[WriteAddr] <= WriteData;
            end
            if (clr_en) begin
                regs[ptr] <= '0;
            end
        end
    end

    // Bypass only in IDLE: during a sweep the pending host write is discarded, so it must not appear.
    always_comb begin
        ReadData1 = '0;
        if (ReadAddr1 != '0) begin
            if (wr_en && (WriteAddr == ReadAddr1)) begin
                ReadData1 = WriteData;
            end else begin
                ReadData1 = regs[ReadAddr1];
            end
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (ReadAddr2 != '0) begin
            if (wr_en && (WriteAddr == ReadAddr2)) begin
                ReadData2 = WriteData;
            end else begin
                ReadData2 = regs[ReadAddr2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_responder.sv
// tb/tb_regfile_responder.sv - scoreboard testbench for regfile_responder
module tb_regfile_responder;

    localparam int SIG_RD1  = 0;
    localparam int SIG_RD2  = 1;
    localparam int SIG_BUSY = 2;
    localparam int SIG_DONE = 3;
    localparam int SIG_DROP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ReadAddr1, ReadAddr2, WriteAddr;
    logic [31:0] WriteData;
    logic        RegWrite, ClearReq;
    logic [31:0] ReadData1, ReadData2;
    logic        ClearBusy, ClearDone, WriteDropped;

    regfile_responder #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .ReadAddr1    (ReadAddr1),
        .ReadAddr2    (ReadAddr2),
        .WriteAddr    (WriteAddr),
        .WriteData    (WriteData),
        .RegWrite     (RegWrite),
        .ClearReq     (ClearReq),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .ClearBusy    (ClearBusy),
        .ClearDone    (ClearDone),
        .WriteDropped (WriteDropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    exp_t        mon_e;
    logic [31:0] mon_act;

    // Expectations are tagged with the cycle they belong to; anything older than now is stale and fails.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            case (mon_e.sig)
                SIG_RD1:  mon_act = ReadData1;
                SIG_RD2:  mon_act = ReadData2;
                SIG_BUSY: mon_act = {31'b0, ClearBusy};
                SIG_DONE: mon_act = {31'b0, ClearDone};
                default:  mon_act = {31'b0, WriteDropped};
            endcase
            checks++;
            if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d (due %0d) got %h want %h",
                         mon_e.name, cyc, mon_e.cyc, mon_act, mon_e.val);
            end
        end
    end

    task automatic expect_val(input int sig, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] wa,
                       input logic [31:0] wd, input logic we, input logic cr);
        ReadAddr1 = a1;
        ReadAddr2 = a2;
        WriteAddr = wa;
        WriteData = wd;
        RegWrite  = we;
        ClearReq  = cr;
    endtask

    initial begin
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b1;

        // Preload, then asynchronous reset must zero everything before any edge
        step(); drv(7, 0, 7, 32'h1111_2222, 1, 0);
        expect_val(SIG_RD1, 32'h1111_2222, "preload_bypass_r7");
        step(); drv(7, 31, 31, 32'h3333_4444, 1, 0);
        expect_val(SIG_RD1, 32'h1111_2222, "preload_stored_r7");
        expect_val(SIG_RD2, 32'h3333_4444, "preload_bypass_r31");
        step(); drv(7, 31, 0, 0, 0, 0);
        expect_val(SIG_RD2, 32'h3333_4444, "preload_stored_r31");
        step();
        reset = 1'b0;
        expect_val(SIG_RD1, 32'h0, "reset_rd1_r7");
        expect_val(SIG_RD2, 32'h0, "reset_rd2_r31");
        expect_val(SIG_BUSY, 32'h0, "reset_busy");
        expect_val(SIG_DONE, 32'h0, "reset_done");
        expect_val(SIG_DROP, 32'h0, "reset_drop");
        step();
        reset = 1'b1;

        // Write with same-cycle bypass, then stored read
        step(); drv(0, 5, 5, 32'hDEAD_BEEF, 1, 0);
        expect_val(SIG_RD2, 32'hDEAD_BEEF, "bypass_r5");
        expect_val(SIG_RD1, 32'h0, "rd1_r0_during_write");
        step(); drv(5, 0, 0, 0, 0, 0);
        expect_val(SIG_RD1, 32'hDEAD_BEEF, "stored_r5");

        // Zero register
        step(); drv(0, 0, 0, 32'hFFFF_FFFF, 1, 0);
        expect_val(SIG_RD1, 32'h0, "r0_same_rd1");
        expect_val(SIG_RD2, 32'h0, "r0_same_rd2");
        expect_val(SIG_DROP, 32'h0, "r0_drop_same");
        step(); drv(0, 0, 0, 0, 0, 0);
        expect_val(SIG_RD1, 32'h0, "r0_next_rd1");
        expect_val(SIG_RD2, 32'h0, "r0_next_rd2");
        expect_val(SIG_DROP, 32'h0, "r0_drop_next");

        // Fill r1..r31 with addr*0x01010101
        for (int a = 1; a < 32; a++) begin
            step(); drv(0, 0, 5'(a), 32'h0101_0101 * a, 1, 0);
        end

        // One-cycle ClearReq, sweep with a dropped write on sweep cycle 5
        step(); drv(0, 0, 0, 0, 0, 1);
        expect_val(SIG_BUSY, 32'h0, "busy_before_sweep");
        for (int j = 1; j <= 31; j++) begin
            step(); drv(0, 0, 0, 0, 0, 0);
            expect_val(SIG_BUSY, 32'h1, "sweep_busy");
            expect_val(SIG_DONE, 32'h0, "sweep_done_low");
            if (j == 3) begin
                drv(1, 4, 0, 0, 0, 0);
                expect_val(SIG_RD1, 32'h0, "sweep_r1_cleared");
                expect_val(SIG_RD2, 32'h0404_0404, "sweep_r4_unswept");
            end
            if (j == 5) begin
                drv(31, 0, 31, 32'h1234_5678, 1, 0);
                expect_val(SIG_RD1, 32'h1F1F_1F1F, "sweep_no_bypass_r31");
                expect_val(SIG_DROP, 32'h0, "drop_low_before");
            end
            if (j == 6) expect_val(SIG_DROP, 32'h1, "drop_pulse");
            if (j == 7) expect_val(SIG_DROP, 32'h0, "drop_one_cycle");
            if (j == 10) begin
                drv(0, 31, 0, 0, 0, 0);
                expect_val(SIG_RD2, 32'h1F1F_1F1F, "sweep10_r31");
            end
        end
        step(); drv(31, 0, 0, 0, 0, 0);
        expect_val(SIG_BUSY, 32'h0, "busy_after_sweep");
        expect_val(SIG_DONE, 32'h1, "done_pulse");
        expect_val(SIG_RD1, 32'h0, "r31_cleared_after_drop");
        step();
        expect_val(SIG_DONE, 32'h0, "done_one_cycle");
        for (int i = 0; i < 16; i++) begin
            step(); drv(5'(2 * i), 5'(2 * i + 1), 0, 0, 0, 0);
            expect_val(SIG_RD1, 32'h0, "post_clear_rd1");
            expect_val(SIG_RD2, 32'h0, "post_clear_rd2");
        end

        // Reset in the middle of a sweep
        step(); drv(0, 0, 30, 32'h3030_3030, 1, 0);
        step(); drv(0, 0, 0, 0, 0, 1);
        for (int j = 1; j < 15; j++) begin
            step(); drv(30, 3, 0, 0, 0, 0);
            expect_val(SIG_BUSY, 32'h1, "sweep2_busy");
        end
        step();
        reset = 1'b0;
        expect_val(SIG_BUSY, 32'h0, "midreset_busy");
        expect_val(SIG_DONE, 32'h0, "midreset_done");
        expect_val(SIG_RD1, 32'h0, "midreset_r30");
        expect_val(SIG_RD2, 32'h0, "midreset_r3");
        step();
        reset = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step();
            expect_val(SIG_BUSY, 32'h0, "after_reset_busy");
            expect_val(SIG_DONE, 32'h0, "after_reset_done");
        end
        step(); drv(3, 0, 3, 32'hA5A5_A5A5, 1, 0);
        expect_val(SIG_RD1, 32'hA5A5_A5A5, "post_reset_bypass_r3");
        step(); drv(3, 30, 0, 0, 0, 0);
        expect_val(SIG_RD1, 32'hA5A5_A5A5, "post_reset_stored_r3");
        expect_val(SIG_RD2, 32'h0, "post_reset_r30");

        step();
        step();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_responder.md
# regfile_responder

Responder end of the register-file access interface: a 2-read/1-write register file with write-to-read bypass, hardwired-zero register 0 and a hardware clear sequencer. It consumes the address/data/write-enable signals driven by the bench driver or the pipeline and returns both read ports within the same cycle, so a monitor sampling at the following negedge sees valid data. It replaces ad-hoc behavioural register-file models as the synthesizable target of the regfile UVM environment.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset
- ReadAddr1  input  ADDR_W  read port 1 address
- ReadAddr2  input  ADDR_W  read port 2 address
- WriteAddr  input  ADDR_W  write address
- WriteData  input  DATA_W  write data
- RegWrite  input  1  write enable
- ClearReq  input  1  start clear sweep (level, sampled in IDLE)
- ReadData1  output  DATA_W  read port 1 data (combinational)
- ReadData2  output  DATA_W  read port 2 data (combinational)
- ClearBusy  output  1  high while sweep in progress
- ClearDone  output  1  one-cycle pulse after the last register is cleared
- WriteDropped  output  1  one-cycle pulse when a host write is discarded during a sweep

## Operation
- Storage: NUM_REGS x DATA_W; reg[0] is not stored and always reads 0; writes to address 0 are ignored (no WriteDropped).
- Reset (reset==0, asynchronous): all registers 0; state IDLE; ptr 0; ClearBusy, ClearDone, WriteDropped 0; ReadData1/2 therefore 0.
- FSM states: IDLE, CLEAR.
- IDLE: on posedge with RegWrite==1 and WriteAddr!=0, reg[WriteAddr] <= WriteData. If ClearReq==1 on the same edge, the write is still applied, and state <= CLEAR, ptr <= 1, ClearBusy <= 1.
- CLEAR: each posedge reg[ptr] <= 0. If ptr == NUM_REGS-1, then state <= IDLE, ClearBusy <= 0, ClearDone <= 1 for one cycle. Otherwise ptr <= ptr+1. ClearReq is ignored in CLEAR.
- Host write in CLEAR: RegWrite==1 with WriteAddr!=0 is discarded, and WriteDropped <= 1 for the following cycle. RegWrite==0 leaves WriteDropped at 0.
- Read path, per port independently:
  - addr==0 gives 0.
  - Otherwise, in IDLE with RegWrite==1 and WriteAddr==addr, the port returns WriteData (bypass).
  - Otherwise it returns reg[addr].
  - In CLEAR there is no bypass. Reads return stored contents: swept registers read 0, unswept registers keep their old value.
- Both ports may read the same address; both see identical data.

## Timing
- Write latency: data written on posedge N is visible from the stored array after that edge. The bypass makes it visible combinationally during cycle N itself.
- Read latency: 0 cycles (combinational from ReadAddr and storage).
- Sweep length: ClearReq sampled at edge E0. Registers 1..NUM_REGS-1 are cleared at edges E1..E(NUM_REGS-1), which is 31 edges for the default. ClearBusy is high from after E0 until after E31. ClearDone is high for exactly the cycle after E31.
- Back-to-back clears: ClearReq held high through completion starts a new sweep at the first IDLE edge after ClearDone, no earlier.
- Reset asserted mid-sweep: immediate return to IDLE with all registers 0 and all status outputs 0; no ClearDone.
- ptr is ADDR_W bits; the terminal test uses all-ones, so there is no wrap past NUM_REGS-1.

## Test plan
- Reset: drive reset=0 after random writes, then ReadAddr1=7 and ReadAddr2=31. Required: ReadData1=ReadData2=0 and ClearBusy=ClearDone=WriteDropped=0 before any clk edge.
- Write/read/bypass: write 0xDEADBEEF to r5 with ReadAddr2=5 in the same cycle. Required: ReadData2=0xDEADBEEF at that negedge, and next cycle ReadAddr1=5 gives 0xDEADBEEF.
- Zero register: write 0xFFFFFFFF to r0 and read r0 on both ports, same cycle and next cycle. Required: 0 on both ports, WriteDropped=0.
- Clear sweep: fill r1..r31 with addr*0x01010101, then pulse ClearReq for one cycle.
  - ClearBusy is high for 31 cycles, then ClearDone is high for 1 cycle.
  - Reading r31 on the 10th sweep cycle returns 0x1F1F1F1F.
  - After ClearDone, all addresses read 0.
- Write during sweep: during CLEAR, write 0x12345678 to r31. Required: WriteDropped pulses one cycle, no bypass value appears, and r31 reads 0 after ClearDone.
- Reset mid-sweep: assert reset on sweep cycle 15. Required: ClearBusy=0 immediately, no ClearDone, all reads 0, and a new write to r3 of 0xA5A5A5A5 is then accepted normally.
